in_port: RTL and testbench

- Receiving end of the router-to-router link whose transmitting end is out_port.
- Accepts flits tagged with a virtual-channel (VC) id and buffers them in per-VC FIFOs.
- Presents the front flit of every VC to the switch allocator and crossbar.
- Returns one credit pulse per VC for every flit dequeued; this is the credit stream the upstream out_port consumes as next_router_credit.
- Per-VC packet state machine tracks head/tail framing and flags protocol violations.

---
 rtl/in_port.sv | 208 ++++++++++++++++++++
 tb/tb_in_port.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_port.sv
// in_port: receiving end of a router-to-router link.
//   Incoming flits are buffered in one circular FIFO per virtual channel (VC).
//   The front flit of every VC goes to the switch allocator and the crossbar.
//   Each flit dequeued from VC v produces a one-cycle credit pulse on
//   credit_out[v] in the next cycle. This pulse returns the buffer slot to
//   the upstream out_port.
//   A per-VC IDLE/ACTIVE machine tracks head/tail framing. Sticky flags record
//   overflow and framing violations.
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   flit_in       incoming flit; bits [1:2] hold the type (10 head, 00 body,
//                 01 tail, 11 head+tail)
//   flit_valid    flit_in and vc_id are valid this cycle
//   vc_id         destination VC of flit_in
//   rd_en         per-VC dequeue request from the switch allocator
//   flit_out      front flit of every VC; VC v is bits [v*FLIT_SIZE+1 +: FLIT_SIZE]
//   vc_valid      VC FIFO non-empty
//   vc_head       VC idle and its front flit starts a packet (allocation request)
//   vc_busy       VC is inside a packet (ACTIVE)
//   credit_out    registered credit pulse per dequeued flit
//   err_overflow  sticky: a write hit a full VC
//   err_seq       sticky: a flit-type sequence violation was dequeued
module in_port #(
   parameter int FLIT_SIZE = 32,
   parameter int VC_SIZE   = 4,
   parameter int VC_W      = 2,
   parameter int BUF_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:FLIT_SIZE]            flit_in,
   input  logic                          flit_valid,
   input  logic [VC_W-1:0]               vc_id,
   input  logic [0:VC_SIZE-1]            rd_en,
   output logic [1:VC_SIZE*FLIT_SIZE]    flit_out,
   output logic [0:VC_SIZE-1]            vc_valid,
   output logic [0:VC_SIZE-1]            vc_head,
   output logic [0:VC_SIZE-1]            vc_busy,
   output logic [0:VC_SIZE-1]            credit_out,
   output logic                          err_overflow,
   output logic                          err_seq
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   localparam logic [1:0] TYPE_BODY = 2'b00;
   localparam logic [1:0] TYPE_TAIL = 2'b01;
   localparam logic [1:0] TYPE_HEAD = 2'b10;
   localparam logic [1:0] TYPE_HT   = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } vc_state_t;

   logic [1:FLIT_SIZE] mem_r    [0:VC_SIZE-1][0:BUF_DEPTH-1];
   logic [PTR_W-1:0]   rd_ptr_r [0:VC_SIZE-1];
   logic [PTR_W-1:0]   wr_ptr_r [0:VC_SIZE-1];
   logic [CNT_W-1:0]   cnt_r    [0:VC_SIZE-1];
   vc_state_t          state_r  [0:VC_SIZE-1];
   vc_state_t          state_nxt_s [0:VC_SIZE-1];

   logic [1:FLIT_SIZE] front_s  [0:VC_SIZE-1];
   logic [1:0]         ftype_s  [0:VC_SIZE-1];
   logic [0:VC_SIZE-1] wr_fire_s;
   logic [0:VC_SIZE-1] rd_fire_s;
   logic [0:VC_SIZE-1] ovf_hit_s;
   logic [0:VC_SIZE-1] seq_hit_s;

   // Front flit of each VC, read combinationally at its read pointer.
   always_comb begin
      for (int v = 0; v < VC_SIZE; v++) begin
         front_s[v] = mem_r[v][rd_ptr_r[v]];
      end
   end

   // Pack the front flits onto flit_out and extract their type fields.
   always_comb begin
      flit_out = {(VC_SIZE*FLIT_SIZE){1'b0}};
      for (int v = 0; v < VC_SIZE; v++) begin
         flit_out[v*FLIT_SIZE+1 +: FLIT_SIZE] = front_s[v];
         ftype_s[v] = {front_s[v][1], front_s[v][2]};
      end
   end

   // Per-VC status and write/read qualification. Fullness is taken from
   // the count at the start of the cycle, so a same-cycle read on a full
   // VC does not make room for the incoming flit.
   always_comb begin
      logic nempty;
      logic full;
      logic hit;
      nempty    = 1'b0;
      full      = 1'b0;
      hit       = 1'b0;
      vc_valid  = {VC_SIZE{1'b0}};
      vc_head   = {VC_SIZE{1'b0}};
      vc_busy   = {VC_SIZE{1'b0}};
      wr_fire_s = {VC_SIZE{1'b0}};
      rd_fire_s = {VC_SIZE{1'b0}};
      ovf_hit_s = {VC_SIZE{1'b0}};
      for (int v = 0; v < VC_SIZE; v++) begin
         nempty       = (cnt_r[v] != CNT_ZERO);
         full         = (cnt_r[v] == CNT_FULL);
         hit          = flit_valid && (vc_id == VC_W'(v));
         vc_valid[v]  = nempty;
         // Head and head+tail both have the leading type bit set.
         vc_head[v]   = nempty && (state_r[v] == IDLE) && ftype_s[v][1];
         vc_busy[v]   = (state_r[v] == ACTIVE);
         wr_fire_s[v] = hit && !full;
         ovf_hit_s[v] = hit && full;
         rd_fire_s[v] = rd_en[v] && nempty;
      end
   end

   // Packet framing state machine, advanced only on a valid dequeue.
   always_comb begin
      for (int v = 0; v < VC_SIZE; v++) begin
         state_nxt_s[v] = state_r[v];
         seq_hit_s[v]   = 1'b0;
         if (rd_fire_s[v]) begin
            case (state_r[v])
               IDLE: begin
                  case (ftype_s[v])
                     TYPE_HEAD: state_nxt_s[v] = ACTIVE;
                     TYPE_HT:   state_nxt_s[v] = IDLE;
                     TYPE_BODY,
                     TYPE_TAIL: begin
                        state_nxt_s[v] = IDLE;
                        seq_hit_s[v]   = 1'b1;
                     end
                     default:   state_nxt_s[v] = IDLE;
                  endcase
               end
               ACTIVE: begin
                  case (ftype_s[v])
                     TYPE_BODY: state_nxt_s[v] = ACTIVE;
                     TYPE_TAIL: state_nxt_s[v] = IDLE;
                     // A head inside a packet is flagged but still opens a new packet.
                     TYPE_HEAD: begin
                        state_nxt_s[v] = ACTIVE;
                        seq_hit_s[v]   = 1'b1;
                     end
                     TYPE_HT: begin
                        state_nxt_s[v] = IDLE;
                        seq_hit_s[v]   = 1'b1;
                     end
                     default:   state_nxt_s[v] = state_r[v];
                  endcase
               end
               default: state_nxt_s[v] = IDLE;
            endcase
         end else begin
            state_nxt_s[v] = state_r[v];
         end
      end
   end

   // FIFO storage write; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_SIZE; v++) begin
         if (wr_fire_s[v]) begin
            mem_r[v][wr_ptr_r[v]] <= flit_in;
         end
      end
   end

   // Pointers, occupancy, VC state, credit pulses and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VC_SIZE; v++) begin
            rd_ptr_r[v] <= PTR_ZERO;
            wr_ptr_r[v] <= PTR_ZERO;
            cnt_r[v]    <= CNT_ZERO;
            state_r[v]  <= IDLE;
         end
         credit_out   <= {VC_SIZE{1'b0}};
         err_overflow <= 1'b0;
         err_seq      <= 1'b0;
      end else begin
         for (int v = 0; v < VC_SIZE; v++) begin
            if (wr_fire_s[v]) begin
               wr_ptr_r[v] <= wr_ptr_r[v] + PTR_ONE;
            end
            if (rd_fire_s[v]) begin
               rd_ptr_r[v] <= rd_ptr_r[v] + PTR_ONE;
            end
            case ({wr_fire_s[v], rd_fire_s[v]})
               2'b10:   cnt_r[v] <= cnt_r[v] + CNT_ONE;
               2'b01:   cnt_r[v] <= cnt_r[v] - CNT_ONE;
               default: cnt_r[v] <= cnt_r[v];
            endcase
            state_r[v] <= state_nxt_s[v];
         end
         credit_out   <= rd_fire_s;
         err_overflow <= err_overflow | (|ovf_hit_s);
         err_seq      <= err_seq | (|seq_hit_s);
      end
   end

endmodule

// File: tb/tb_in_port.sv
// tb_in_port: self-checking bench for in_port.
//   A per-VC scoreboard queue receives every flit the model accepts. It pops
//   the expected flit whenever the bench dequeues that VC, and the popped flit
//   is compared with the flit the DUT presented. The model also tracks framing
//   state, sticky flags and expected credit pulses.
//   Inputs change after the falling edge, and outputs are sampled at the
//   falling edge.
module tb_in_port;
   localparam int FS  = 32;
   localparam int VCN = 4;
   localparam int VW  = 2;
   localparam int BD  = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:FS]        flit_in;
   logic               flit_valid;
   logic [VW-1:0]      vc_id;
   logic [0:VCN-1]     rd_en;
   logic [1:VCN*FS]    flit_out;
   logic [0:VCN-1]     vc_valid, vc_head, vc_busy, credit_out;
   logic               err_overflow, err_seq;

   always #5 clk = ~clk;

   in_port #(.FLIT_SIZE(FS), .VC_SIZE(VCN), .VC_W(VW), .BUF_DEPTH(BD)) dut (
      .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
      .vc_id(vc_id), .rd_en(rd_en), .flit_out(flit_out), .vc_valid(vc_valid),
      .vc_head(vc_head), .vc_busy(vc_busy), .credit_out(credit_out),
      .err_overflow(err_overflow), .err_seq(err_seq)
   );

   int n_cmp = 0;
   int n_err = 0;
   int n_deq = 0;

   // scoreboard and reference model
   logic [1:FS]    mq [0:VCN-1][$];
   logic           mact [0:VCN-1];
   logic           m_ovf, m_seq;
   logic [0:VCN-1] m_credit;
   logic [0:VCN-1] deq_mask;
   logic [1:FS]    deq_obs [0:VCN-1];
   logic [1:FS]    deq_exp [0:VCN-1];

   function automatic logic [1:FS] mk(input logic [1:0] t, input logic [29:0] p);
      return {t, p};
   endfunction

   function automatic logic [1:FS] slice(input int v);
      return flit_out[v*FS+1 +: FS];
   endfunction

   function automatic logic [0:VCN-1] exp_valid();
      logic [0:VCN-1] r;
      for (int v = 0; v < VCN; v++) r[v] = (mq[v].size() != 0);
      return r;
   endfunction

   function automatic logic [0:VCN-1] exp_head();
      logic [0:VCN-1] r;
      for (int v = 0; v < VCN; v++) begin
         r[v] = 1'b0;
         if (mq[v].size() != 0) r[v] = !mact[v] && mq[v][0][1];
      end
      return r;
   endfunction

   function automatic logic [0:VCN-1] exp_busy();
      logic [0:VCN-1] r;
      for (int v = 0; v < VCN; v++) r[v] = mact[v];
      return r;
   endfunction

   task automatic model_clear();
      for (int v = 0; v < VCN; v++) begin
         mq[v].delete();
         mact[v] = 1'b0;
      end
      m_ovf = 1'b0;
      m_seq = 1'b0;
      m_credit = 4'b0000;
   endtask

   task automatic do_reset(input logic [0:VCN-1] rd);
      rst = 1'b1;
      flit_valid = 1'b0;
      rd_en = rd;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rd_en = 4'b0000;
      model_clear();
   endtask

   // One clock of stimulus: drive, update model/scoreboard, advance to the next falling edge.
   task automatic cycle(input logic fv, input logic [VW-1:0] vid, input logic [1:FS] fl,
                        input logic [0:VCN-1] rd);
      logic full;
      logic [1:0] t;
      flit_valid = fv;
      vc_id = vid;
      flit_in = fl;
      rd_en = rd;
      #1;
      full = (mq[vid].size() == BD);
      for (int v = 0; v < VCN; v++) begin
         deq_mask[v] = 1'b0;
         if (rd[v] && mq[v].size() != 0) begin
            deq_mask[v] = 1'b1;
            deq_obs[v] = slice(v);
            deq_exp[v] = mq[v].pop_front();
            t = {deq_exp[v][1], deq_exp[v][2]};
            if (!mact[v]) begin
               if (t == 2'b10) mact[v] = 1'b1;
               else if (t != 2'b11) m_seq = 1'b1;
            end else begin
               if (t == 2'b01) mact[v] = 1'b0;
               else if (t == 2'b10) m_seq = 1'b1;
               else if (t == 2'b11) begin m_seq = 1'b1; mact[v] = 1'b0; end
            end
         end
      end
      if (fv) begin
         if (!full) mq[vid].push_back(fl);
         else m_ovf = 1'b1;
      end
      m_credit = deq_mask;
      n_deq += $countones(deq_mask);
      @(posedge clk);
      @(negedge clk);
      flit_valid = 1'b0;
      rd_en = 4'b0000;
   endtask

   task automatic test_reset();
      do_reset(4'b0000);
      n_cmp++; if (vc_valid !== 4'b0000) begin n_err++; $display("FAIL rst_valid: got %b want 0000", vc_valid); end
      n_cmp++; if (vc_head !== 4'b0000) begin n_err++; $display("FAIL rst_head: got %b want 0000", vc_head); end
      n_cmp++; if (vc_busy !== 4'b0000) begin n_err++; $display("FAIL rst_busy: got %b want 0000", vc_busy); end
      n_cmp++; if (credit_out !== 4'b0000) begin n_err++; $display("FAIL rst_credit: got %b want 0000", credit_out); end
      n_cmp++; if ({err_overflow, err_seq} !== 2'b00) begin n_err++; $display("FAIL rst_errs: got %b want 00", {err_overflow, err_seq}); end
   endtask

   task automatic test_single();
      logic [1:FS] f;
      f = mk(2'b11, 30'h3ABCDEF0);
      cycle(1'b1, 2'd2, f, 4'b0000);
      n_cmp++; if (vc_valid !== 4'b0010) begin n_err++; $display("FAIL single_valid: got %b want 0010", vc_valid); end
      n_cmp++; if (vc_head !== 4'b0010) begin n_err++; $display("FAIL single_head: got %b want 0010", vc_head); end
      n_cmp++; if (slice(2) !== 32'hFABCDEF0) begin n_err++; $display("FAIL single_flit: got %h want fabcdef0", slice(2)); end
      cycle(1'b0, 2'd0, 32'h0, 4'b0010);
      n_cmp++; if (deq_obs[2] !== deq_exp[2]) begin n_err++; $display("FAIL single_deq: got %h want %h", deq_obs[2], deq_exp[2]); end
      n_cmp++; if (credit_out !== 4'b0010) begin n_err++; $display("FAIL single_credit: got %b want 0010", credit_out); end
      n_cmp++; if (vc_valid !== 4'b0000) begin n_err++; $display("FAIL single_empty: got %b want 0000", vc_valid); end
      n_cmp++; if (vc_busy !== 4'b0000) begin n_err++; $display("FAIL single_busy: got %b want 0000", vc_busy); end
      cycle(1'b0, 2'd0, 32'h0, 4'b0000);
      n_cmp++; if (credit_out !== 4'b0000) begin n_err++; $display("FAIL single_credit_once: got %b want 0000", credit_out); end
   endtask

   task automatic test_packet();
      logic [1:0] types [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'd1, mk(types[i], 30'h100 + 30'(i)), 4'b0000);
      n_cmp++; if (vc_head !== exp_head()) begin n_err++; $display("FAIL pkt_head: got %b want %b", vc_head, exp_head()); end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 2'd0, 32'h0, 4'b0100);
         n_cmp++; if (deq_obs[1] !== deq_exp[1]) begin n_err++; $display("FAIL pkt_flit%0d: got %h want %h", i, deq_obs[1], deq_exp[1]); end
         n_cmp++; if (credit_out !== 4'b0100) begin n_err++; $display("FAIL pkt_credit%0d: got %b want 0100", i, credit_out); end
         n_cmp++; if (vc_busy[1] !== (i < 3)) begin n_err++; $display("FAIL pkt_busy%0d: got %b want %b", i, vc_busy[1], (i < 3)); end
      end
      cycle(1'b0, 2'd0, 32'h0, 4'b0000);
      n_cmp++; if (credit_out !== 4'b0000) begin n_err++; $display("FAIL pkt_credit_end: got %b want 0000", credit_out); end
      n_cmp++; if (err_seq !== 1'b0) begin n_err++; $display("FAIL pkt_seq: got %b want 0", err_seq); end
   endtask

   task automatic test_overflow();
      logic [1:0] types [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'd0, mk(types[i], 30'h200 + 30'(i)), 4'b0000);
      n_cmp++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
      cycle(1'b1, 2'd0, mk(2'b01, 30'h3FFFFFFF), 4'b1000);
      n_cmp++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
      n_cmp++; if (deq_obs[0] !== deq_exp[0]) begin n_err++; $display("FAIL ovf_deq: got %h want %h", deq_obs[0], deq_exp[0]); end
      for (int j = 0; j < 3; j++) begin
         cycle(1'b0, 2'd0, 32'h0, 4'b1000);
         n_cmp++; if (deq_obs[0] !== deq_exp[0]) begin n_err++; $display("FAIL ovf_order%0d: got %h want %h", j, deq_obs[0], deq_exp[0]); end
         n_cmp++; if (vc_valid[0] !== (j < 2)) begin n_err++; $display("FAIL ovf_count%0d: got %b want %b", j, vc_valid[0], (j < 2)); end
      end
      n_cmp++; if ({err_overflow, err_seq} !== {m_ovf, m_seq}) begin n_err++; $display("FAIL ovf_errs: got %b want %b", {err_overflow, err_seq}, {m_ovf, m_seq}); end
   endtask

   task automatic test_interleave();
      int credits;
      credits = 0;
      n_deq = 0;
      cycle(1'b1, 2'd0, mk(2'b11, 30'h300), 4'b0000);
      cycle(1'b1, 2'd3, mk(2'b11, 30'h310), 4'b0000);
      cycle(1'b1, 2'd0, mk(2'b11, 30'h301), 4'b0000);
      cycle(1'b1, 2'd3, mk(2'b11, 30'h311), 4'b0000);
      for (int i = 0; i < 8; i++) begin
         if (i < 4) cycle(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, mk(2'b11, 30'h320 + 30'(i)), 4'b1001);
         else cycle(1'b0, 2'd0, 32'h0, 4'b1001);
         for (int v = 0; v < VCN; v++) begin
            if (deq_mask[v]) begin
               n_cmp++; if (deq_obs[v] !== deq_exp[v]) begin n_err++; $display("FAIL ilv_flit c%0d vc%0d: got %h want %h", i, v, deq_obs[v], deq_exp[v]); end
            end
         end
         n_cmp++; if (credit_out !== m_credit) begin n_err++; $display("FAIL ilv_credit c%0d: got %b want %b", i, credit_out, m_credit); end
         n_cmp++; if (vc_head !== exp_head()) begin n_err++; $display("FAIL ilv_head c%0d: got %b want %b", i, vc_head, exp_head()); end
         credits += $countones(credit_out);
      end
      n_cmp++; if (credits !== 8) begin n_err++; $display("FAIL ilv_total: got %0d credits want 8", credits); end
      n_cmp++; if (credits !== n_deq) begin n_err++; $display("FAIL ilv_vs_deq: got %0d credits want %0d", credits, n_deq); end
      n_cmp++; if (vc_valid !== 4'b0000) begin n_err++; $display("FAIL ilv_drained: got %b want 0000", vc_valid); end
   endtask

   task automatic test_body_idle();
      cycle(1'b1, 2'd2, mk(2'b00, 30'h0BAD), 4'b0000);
      n_cmp++; if (vc_valid !== exp_valid()) begin n_err++; $display("FAIL body_valid: got %b want %b", vc_valid, exp_valid()); end
      n_cmp++; if (vc_head[2] !== 1'b0) begin n_err++; $display("FAIL body_head: got %b want 0", vc_head[2]); end
      n_cmp++; if (err_seq !== 1'b0) begin n_err++; $display("FAIL body_seq_pre: got %b want 0", err_seq); end
      cycle(1'b0, 2'd0, 32'h0, 4'b0010);
      n_cmp++; if (deq_obs[2] !== deq_exp[2]) begin n_err++; $display("FAIL body_deq: got %h want %h", deq_obs[2], deq_exp[2]); end
      n_cmp++; if (err_seq !== 1'b1) begin n_err++; $display("FAIL body_seq: got %b want 1", err_seq); end
      n_cmp++; if (vc_busy !== exp_busy()) begin n_err++; $display("FAIL body_busy: got %b want %b", vc_busy, exp_busy()); end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 2'd2, mk(2'b10, 30'h400), 4'b0000);
      cycle(1'b1, 2'd2, mk(2'b00, 30'h401), 4'b0000);
      cycle(1'b1, 2'd2, mk(2'b00, 30'h402), 4'b0000);
      cycle(1'b0, 2'd0, 32'h0, 4'b0010);
      n_cmp++; if (vc_busy !== 4'b0010) begin n_err++; $display("FAIL mid_busy: got %b want 0010", vc_busy); end
      n_cmp++; if ({err_overflow, err_seq} !== {m_ovf, m_seq}) begin n_err++; $display("FAIL mid_errs_pre: got %b want %b", {err_overflow, err_seq}, {m_ovf, m_seq}); end
      do_reset(4'b0010);
      n_cmp++; if (vc_valid !== 4'b0000) begin n_err++; $display("FAIL mid_valid: got %b want 0000", vc_valid); end
      n_cmp++; if (vc_busy !== 4'b0000) begin n_err++; $display("FAIL mid_busy_rst: got %b want 0000", vc_busy); end
      n_cmp++; if (credit_out !== 4'b0000) begin n_err++; $display("FAIL mid_credit: got %b want 0000", credit_out); end
      n_cmp++; if ({err_overflow, err_seq} !== 2'b00) begin n_err++; $display("FAIL mid_errs: got %b want 00", {err_overflow, err_seq}); end
      cycle(1'b1, 2'd2, mk(2'b10, 30'h500), 4'b0000);
      n_cmp++; if (credit_out !== 4'b0000) begin n_err++; $display("FAIL mid_credit2: got %b want 0000", credit_out); end
      n_cmp++; if (vc_head !== 4'b0010) begin n_err++; $display("FAIL mid_newhead: got %b want 0010", vc_head); end
      n_cmp++; if (slice(2) !== mk(2'b10, 30'h500)) begin n_err++; $display("FAIL mid_newflit: got %h want %h", slice(2), mk(2'b10, 30'h500)); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      flit_in = 32'h0;
      flit_valid = 1'b0;
      vc_id = 2'd0;
      rd_en = 4'b0000;
      model_clear();
      test_reset();
      test_single();
      test_packet();
      test_overflow();
      test_interleave();
      test_body_idle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
